// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a big-endian 16-bit instruction image into the
// byte-wide instruction memory starting at the PC reset address. It holds the
// CPU while the load runs, pulses Done when finished and flags oversize loads.
//
// Stream handshake: a byte is accepted on a rising Clock edge where
// InValid & InReady are both high. InReady is decoded from the state alone
// (high in HI and LO) and does not depend on InValid. The producer may drop
// InValid for any number of cycles, and the loader simply waits.
//
// StateDbg encoding: 0 = IDLE, 1 = HI, 2 = LO, 3 = FIN.
module instr_mem_loader #(
  parameter int MEM_BYTES  = 128,
  parameter int START_ADDR = 10,
  parameter int LEN_W      = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [LEN_W-1:0] WordCount,
  input  logic             InValid,
  input  logic [7:0]       InByte,
  output logic             InReady,
  output logic             MemWrite,
  output logic [15:0]      MemAddr,
  output logic [7:0]       MemByte,
  output logic             CpuHold,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [1:0]       StateDbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [15:0]      ptr;
  logic [LEN_W-1:0] remaining;
  logic [16:0]      end_addr;
  logic             overflow;
  logic             accept;
  logic             start_seen;

  // One past the last byte the requested load would write. It is computed
  // 17 bits wide so that a huge WordCount cannot wrap into a legal value.
  assign end_addr   = 17'(START_ADDR) + 17'({WordCount, 1'b0});
  assign overflow   = end_addr > 17'(MEM_BYTES);
  assign accept     = InValid & InReady;
  assign start_seen = (state == S_IDLE) & Start;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nx = state;
    InReady  = 1'b0;
    Busy     = 1'b0;
    CpuHold  = 1'b0;
    Done     = 1'b0;
    StateDbg = state;
    case (state)
      S_IDLE: begin
        if (Start && !overflow) begin
          if (WordCount == '0) state_nx = S_FIN;
          else                 state_nx = S_HI;
        end
      end
      S_HI: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        CpuHold = 1'b1;
        if (accept) state_nx = S_LO;
      end
      S_LO: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        CpuHold = 1'b1;
        if (accept) begin
          if (remaining == LEN_W'(1)) state_nx = S_FIN;
          else                        state_nx = S_HI;
        end
      end
      S_FIN: begin
        CpuHold  = 1'b1;
        Done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: write pointer, word counter, registered memory write and sticky error
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr       <= '0;
      remaining <= '0;
      MemWrite  <= 1'b0;
      MemAddr   <= '0;
      MemByte   <= '0;
      Error     <= 1'b0;
    end else begin
      MemWrite <= accept;
      if (accept) begin
        MemAddr <= ptr;
        MemByte <= InByte;
        ptr     <= ptr + 16'd1;
        if (state == S_LO) remaining <= remaining - LEN_W'(1);
      end
      if (start_seen) begin
        Error <= overflow;
        if (!overflow) begin
          ptr       <= 16'(START_ADDR);
          remaining <= WordCount;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random program images checked against a
// scoreboard of expected (address, byte) writes built from the load rules.
module tb_instr_mem_loader;

  localparam int MEM_BYTES  = 128;
  localparam int START_ADDR = 10;
  localparam int LEN_W      = 8;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             Start;
  logic [LEN_W-1:0] WordCount;
  logic             InValid;
  logic [7:0]       InByte;
  logic             InReady;
  logic             MemWrite;
  logic [15:0]      MemAddr;
  logic [7:0]       MemByte;
  logic             CpuHold;
  logic             Busy;
  logic             Done;
  logic             Error;
  logic [1:0]       StateDbg;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [23:0] exp_q[$];

  instr_mem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .START_ADDR(START_ADDR),
    .LEN_W     (LEN_W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .WordCount(WordCount),
    .InValid  (InValid),
    .InByte   (InByte),
    .InReady  (InReady),
    .MemWrite (MemWrite),
    .MemAddr  (MemAddr),
    .MemByte  (MemByte),
    .CpuHold  (CpuHold),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .StateDbg (StateDbg)
  );

  // Clock
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every memory write must match the oldest outstanding byte
  always @(negedge Clock) begin
    if (!Reset && MemWrite) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {8'h0, MemAddr, MemByte}, 32'hFFFFFFFF);
      end else begin
        check("write_addr_data", {8'h0, MemAddr, MemByte}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // Issue a one-cycle Start; leaves the bench at posedge+1 of the cycle after
  task automatic pulse_start(input int n);
    @(posedge Clock); #1;
    Start     = 1'b1;
    WordCount = LEN_W'(n);
    @(posedge Clock); #1;
    Start     = 1'b0;
  endtask

  // Offer stream byte number i of the image; returns once it has been accepted
  task automatic send_byte(input int i, input int gap, input bit poke_start);
    logic [7:0] b;
    repeat (gap) begin
      InValid = 1'b0;
      @(posedge Clock); #1;
      check("ready_in_gap", InReady, 1);
      check("hold_in_gap", CpuHold, 1);
    end
    b       = 8'($urandom_range(0, 255));
    InValid = 1'b1;
    InByte  = b;
    exp_q.push_back({16'(START_ADDR + i), b});
    if (poke_start) begin
      Start     = 1'b1;
      WordCount = LEN_W'(3);
    end
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  // One complete load; gap < 0 picks a random 0..3 cycle gap per byte
  task automatic do_load(input int n, input int gap, input bit poke_start);
    int base;
    int g;
    base = wr_cnt;
    pulse_start(n);
    if (START_ADDR + 2 * n > MEM_BYTES) begin
      check("ovf_error", Error, 1);
      check("ovf_hold", CpuHold, 0);
      check("ovf_busy", Busy, 0);
      repeat (3) @(posedge Clock);
      #1;
      check("ovf_no_write", 32'(wr_cnt - base), 0);
      check("ovf_sticky", Error, 1);
      return;
    end
    check("start_err_clr", Error, 0);
    check("start_hold", CpuHold, 1);
    if (n == 0) begin
      check("zero_done", Done, 1);
      check("zero_busy", Busy, 0);
      @(posedge Clock); #1;
      check("zero_done_end", Done, 0);
      check("zero_hold_end", CpuHold, 0);
      check("zero_no_write", 32'(wr_cnt - base), 0);
      return;
    end
    check("start_busy", Busy, 1);
    for (int i = 0; i < 2 * n; i++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : ((i == 0) ? 0 : gap);
      send_byte(i, g, poke_start && (i == 1));
    end
    InValid = 1'b0;
    check("fin_done", Done, 1);
    check("fin_last_write", MemWrite, 1);
    check("fin_last_addr", MemAddr, 32'(START_ADDR + 2 * n - 1));
    check("fin_hold", CpuHold, 1);
    check("fin_busy", Busy, 0);
    @(posedge Clock); #1;
    check("idle_done_low", Done, 0);
    check("idle_hold_low", CpuHold, 0);
    check("idle_ready_low", InReady, 0);
    check("idle_write_low", MemWrite, 0);
    check("idle_state", StateDbg, 0);
    check("idle_error", Error, 0);
    check("write_count", 32'(wr_cnt - base), 32'(2 * n));
    check("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_outputs"},
          {MemWrite, InReady, CpuHold, Busy, Done, Error, StateDbg}, 0);
    check({tag, "_addr_byte"}, {8'h0, MemAddr, MemByte}, 0);
  endtask

  initial begin
    Reset     = 1'b1;
    Start     = 1'b0;
    WordCount = '0;
    InValid   = 1'b0;
    InByte    = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_all_clear("reset");
    Reset = 1'b0;

    // Back-to-back two-word load
    do_load(2, 0, 1'b0);
    // Gapped single word
    do_load(1, 3, 1'b0);
    // Largest load that fits, then one word too many
    do_load(59, 0, 1'b0);
    do_load(60, 0, 1'b0);
    // Empty load, and it clears the sticky error
    do_load(0, 0, 1'b0);
    // Start pulsed mid-load is ignored
    do_load(4, 0, 1'b1);

    // Asynchronous reset after 3 of 4 bytes
    pulse_start(2);
    for (int i = 0; i < 3; i++) send_byte(i, 0, 1'b0);
    InValid = 1'b0;
    @(negedge Clock); #1;
    Reset = 1'b1;
    #1;
    check_all_clear("async_reset");
    check("async_reset_sb", 32'(exp_q.size()), 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    do_load(1, 0, 1'b0);

    // Randomized loads, including some oversize requests
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(60, 255), 0, 1'b0);
      else                           do_load($urandom_range(0, 59), -1, ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
